// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory port between CPU MEM stage and accelerator bursts
module dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int BURST_MAX    = 16,
    parameter int CPU_WAIT_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_memread,
    input  logic              cpu_memwrite,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              acc_req,
    input  logic              acc_we,
    input  logic              acc_last,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [DATA_W-1:0] acc_wdata,
    output logic              acc_gnt,
    output logic [DATA_W-1:0] acc_rdata,
    output logic              acc_rvalid,
    output logic              acc_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam int WW = $clog2(CPU_WAIT_MAX + 1);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t        state, state_n;
    logic [BW-1:0] beat_cnt, beat_n;
    logic [WW-1:0] wait_cnt, wait_n;
    logic          cpu_req, cpu_sel, acc_sel, stall, cpu_srv, acc_srv;

    assign cpu_req = cpu_memread | cpu_memwrite;

    // Grant decision and next-state: CPU wins in IDLE, accelerator holds the port in LOCK unless starved CPU steals a cycle
    always_comb begin
        cpu_sel  = 1'b0;
        acc_sel  = 1'b0;
        stall    = 1'b0;
        state_n  = state;
        beat_n   = beat_cnt;
        wait_n   = wait_cnt;
        if (state == IDLE) begin
            if (cpu_req) begin
                cpu_sel = 1'b1;
            end else if (acc_req) begin
                acc_sel = 1'b1;
                if (!acc_last) begin
                    state_n = LOCK;
                    beat_n  = BW'(1);
                end
            end
        end else if (cpu_req && wait_cnt == WW'(CPU_WAIT_MAX)) begin
            cpu_sel = 1'b1;
            wait_n  = '0;
        end else if (acc_req) begin
            acc_sel = 1'b1;
            stall   = cpu_req;
            beat_n  = beat_cnt + BW'(1);
            wait_n  = cpu_req ? wait_cnt + WW'(1) : '0;
            if (acc_last || beat_cnt + BW'(1) == BW'(BURST_MAX)) begin
                state_n = IDLE;
                beat_n  = '0;
                wait_n  = '0;
            end
        end else begin
            cpu_sel = cpu_req;
            wait_n  = '0;
        end
    end

    assign cpu_srv    = rst & cpu_sel;
    assign acc_srv    = rst & acc_sel;
    assign acc_gnt    = acc_srv;
    assign cpu_stall  = rst & stall;
    assign acc_busy   = state == LOCK;
    assign cpu_rdata  = mem_rdata;
    assign mem_addr   = cpu_srv ? cpu_addr : acc_srv ? acc_addr : '0;
    assign mem_wdata  = cpu_srv ? cpu_wdata : acc_srv ? acc_wdata : '0;
    assign mem_read   = cpu_srv ? cpu_memread : acc_srv & ~acc_we;
    assign mem_write  = cpu_srv ? cpu_memwrite : acc_srv & acc_we;

    // Arbitration state, counters and registered accelerator read return
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            wait_cnt   <= '0;
            acc_rvalid <= 1'b0;
            acc_rdata  <= '0;
        end else begin
            state      <= state_n;
            beat_cnt   <= beat_n;
            wait_cnt   <= wait_n;
            acc_rvalid <= acc_gnt & ~acc_we;
            if (acc_gnt && !acc_we)
                acc_rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
    logic        clk = 0;
    logic        rst = 0;
    logic        cpu_memread = 0, cpu_memwrite = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, cpu_rdata;
    logic        cpu_stall;
    logic        acc_req = 0, acc_we = 0, acc_last = 0;
    logic [31:0] acc_addr = 0, acc_wdata = 0, acc_rdata;
    logic        acc_gnt, acc_rvalid, acc_busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem [0:255];
    int          asserts = 0;
    int          fails = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_MAX(16), .CPU_WAIT_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .acc_req(acc_req), .acc_we(acc_we), .acc_last(acc_last), .acc_addr(acc_addr),
        .acc_wdata(acc_wdata), .acc_gnt(acc_gnt), .acc_rdata(acc_rdata),
        .acc_rvalid(acc_rvalid), .acc_busy(acc_busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Simple word-addressed memory: combinational read, write on rising edge
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic acc_idle();
        acc_req = 0; acc_we = 0; acc_last = 0; acc_addr = 0; acc_wdata = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        #2;
        asserts++; if ({acc_gnt, cpu_stall, mem_read, mem_write} !== 4'b0) begin fails++; $display("FAIL reset_comb: got %b want 0000", {acc_gnt, cpu_stall, mem_read, mem_write}); end
        asserts++; if ({acc_busy, acc_rvalid} !== 2'b0 || acc_rdata !== 32'h0) begin fails++; $display("FAIL reset_regs: busy=%b rvalid=%b rdata=%h want 0", acc_busy, acc_rvalid, acc_rdata); end
        step();
        rst = 1;
        step();
        asserts++; if (mem_addr !== 0 || mem_wdata !== 0 || mem_read !== 0 || mem_write !== 0 || acc_busy !== 0 || acc_gnt !== 0) begin fails++; $display("FAIL idle_outputs: addr=%h rd=%b wr=%b busy=%b gnt=%b want all 0", mem_addr, mem_read, mem_write, acc_busy, acc_gnt); end
    endtask

    task automatic test_idle_priority();
        mem[8'h40] = 32'h1234_5678;
        cpu_memread = 1; cpu_addr = 32'h40;
        acc_req = 1; acc_we = 0; acc_last = 1; acc_addr = 32'h100;
        #1;
        asserts++; if (mem_addr !== 32'h40 || mem_read !== 1 || cpu_stall !== 0 || acc_gnt !== 0) begin fails++; $display("FAIL idle_cpu_first: addr=%h rd=%b stall=%b gnt=%b want 40 1 0 0", mem_addr, mem_read, cpu_stall, acc_gnt); end
        step();
        cpu_memread = 0;
        #1;
        asserts++; if (acc_gnt !== 1 || mem_addr !== 32'h100 || mem_read !== 1) begin fails++; $display("FAIL idle_acc_next: gnt=%b addr=%h want 1 100", acc_gnt, mem_addr); end
        step();
        acc_idle();
        #1;
        asserts++; if (acc_rvalid !== 1 || acc_rdata !== 32'h1234_5678 || acc_busy !== 0) begin fails++; $display("FAIL idle_single_beat: rvalid=%b rdata=%h busy=%b want 1 12345678 0", acc_rvalid, acc_rdata, acc_busy); end
    endtask

    task automatic test_burst_read();
        for (int i = 0; i < 4; i++) mem[8'h80 + i] = 32'hA0 + i;
        for (int i = 0; i < 4; i++) begin
            acc_req = 1; acc_we = 0; acc_addr = 32'h200 + 4 * i; acc_last = (i == 3);
            #1;
            asserts++; if (acc_gnt !== 1 || acc_busy !== (i > 0)) begin fails++; $display("FAIL burst_beat%0d: gnt=%b busy=%b want 1 %b", i, acc_gnt, acc_busy, i > 0); end
            if (i > 0) begin
                asserts++; if (acc_rvalid !== 1 || acc_rdata !== 32'hA0 + i - 1) begin fails++; $display("FAIL burst_rdata%0d: rvalid=%b rdata=%h want 1 %h", i, acc_rvalid, acc_rdata, 32'hA0 + i - 1); end
            end
            step();
        end
        acc_idle();
        #1;
        asserts++; if (acc_rvalid !== 1 || acc_rdata !== 32'hA3 || acc_busy !== 0) begin fails++; $display("FAIL burst_end: rvalid=%b rdata=%h busy=%b want 1 a3 0", acc_rvalid, acc_rdata, acc_busy); end
        step();
        asserts++; if (acc_rvalid !== 0) begin fails++; $display("FAIL burst_rvalid_drop: got %b want 0", acc_rvalid); end
    endtask

    task automatic test_forced_release();
        for (int i = 0; i < 20; i++) begin
            acc_req = 1; acc_we = 0; acc_addr = 32'h300 + 4 * i; acc_last = (i == 19);
            #1;
            asserts++; if (acc_gnt !== 1 || acc_busy !== ((i >= 1 && i <= 15) || i >= 17)) begin fails++; $display("FAIL forced_beat%0d: gnt=%b busy=%b want 1 %b", i + 1, acc_gnt, acc_busy, (i >= 1 && i <= 15) || i >= 17); end
            step();
            if (i == 15) begin
                asserts++; if (dut.beat_cnt !== 0 || acc_busy !== 0) begin fails++; $display("FAIL forced_exit: beat_cnt=%0d busy=%b want 0 0", dut.beat_cnt, acc_busy); end
            end
        end
        acc_idle();
        #1;
        asserts++; if (acc_busy !== 0) begin fails++; $display("FAIL forced_done: busy=%b want 0", acc_busy); end
    endtask

    task automatic test_cpu_steal();
        mem[8'h20] = 32'h0;
        acc_req = 1; acc_we = 0; acc_last = 0; acc_addr = 32'h300;
        step();
        cpu_memwrite = 1; cpu_addr = 32'h80; cpu_wdata = 32'h55;
        for (int k = 0; k < 4; k++) begin
            acc_addr = 32'h304 + 4 * k;
            #1;
            asserts++; if (cpu_stall !== 1 || acc_gnt !== 1 || mem_write !== 0) begin fails++; $display("FAIL steal_wait%0d: stall=%b gnt=%b wr=%b want 1 1 0", k, cpu_stall, acc_gnt, mem_write); end
            step();
        end
        acc_addr = 32'h314;
        #1;
        asserts++; if (cpu_stall !== 0 || acc_gnt !== 0 || mem_write !== 1 || mem_addr !== 32'h80 || mem_wdata !== 32'h55) begin fails++; $display("FAIL steal_cycle: stall=%b gnt=%b wr=%b addr=%h wdata=%h want 0 0 1 80 55", cpu_stall, acc_gnt, mem_write, mem_addr, mem_wdata); end
        asserts++; if (dut.beat_cnt !== 5) begin fails++; $display("FAIL steal_beat_cnt: got %0d want 5", dut.beat_cnt); end
        step();
        cpu_memwrite = 0;
        #1;
        asserts++; if (mem[8'h20] !== 32'h55 || dut.beat_cnt !== 5 || dut.wait_cnt !== 0 || acc_gnt !== 1 || acc_busy !== 1) begin fails++; $display("FAIL steal_resume: mem=%h beat=%0d wait=%0d gnt=%b busy=%b want 55 5 0 1 1", mem[8'h20], dut.beat_cnt, dut.wait_cnt, acc_gnt, acc_busy); end
        acc_last = 1;
        step();
        acc_idle();
        #1;
        asserts++; if (acc_busy !== 0) begin fails++; $display("FAIL steal_done: busy=%b want 0", acc_busy); end
    endtask

    task automatic test_bubble();
        mem[8'h11] = 32'hBEEF;
        acc_req = 1; acc_we = 0; acc_last = 0; acc_addr = 32'h300;
        step();
        cpu_memread = 1; cpu_addr = 32'h44; acc_addr = 32'h304;
        #1;
        asserts++; if (cpu_stall !== 1 || acc_gnt !== 1) begin fails++; $display("FAIL bubble_pre: stall=%b gnt=%b want 1 1", cpu_stall, acc_gnt); end
        step();
        acc_req = 0;
        #1;
        asserts++; if (cpu_stall !== 0 || acc_gnt !== 0 || mem_read !== 1 || mem_addr !== 32'h44 || cpu_rdata !== 32'hBEEF || acc_busy !== 1) begin fails++; $display("FAIL bubble_cpu: stall=%b gnt=%b rd=%b addr=%h rdata=%h busy=%b want 0 0 1 44 beef 1", cpu_stall, acc_gnt, mem_read, mem_addr, cpu_rdata, acc_busy); end
        step();
        cpu_memread = 0; acc_req = 1; acc_last = 1; acc_addr = 32'h308;
        #1;
        asserts++; if (dut.wait_cnt !== 0 || acc_busy !== 1 || acc_gnt !== 1) begin fails++; $display("FAIL bubble_after: wait=%0d busy=%b gnt=%b want 0 1 1", dut.wait_cnt, acc_busy, acc_gnt); end
        step();
        acc_idle();
        #1;
        asserts++; if (acc_busy !== 0) begin fails++; $display("FAIL bubble_done: busy=%b want 0", acc_busy); end
    endtask

    task automatic test_reset_mid_burst();
        mem[8'hF0] = 32'h0;
        acc_req = 1; acc_we = 0; acc_last = 0; acc_addr = 32'h300;
        step();
        acc_addr = 32'h304;
        step();
        acc_we = 1; acc_addr = 32'h3C0; acc_wdata = 32'hDEAD;
        #1;
        asserts++; if (acc_busy !== 1 || acc_rvalid !== 1 || acc_gnt !== 1 || mem_write !== 1) begin fails++; $display("FAIL rst_pre: busy=%b rvalid=%b gnt=%b wr=%b want 1 1 1 1", acc_busy, acc_rvalid, acc_gnt, mem_write); end
        rst = 0;
        #1;
        asserts++; if (acc_busy !== 0 || acc_rvalid !== 0 || acc_gnt !== 0 || mem_write !== 0) begin fails++; $display("FAIL rst_mid: busy=%b rvalid=%b gnt=%b wr=%b want 0 0 0 0", acc_busy, acc_rvalid, acc_gnt, mem_write); end
        step();
        asserts++; if (mem[8'hF0] !== 32'h0 || dut.beat_cnt !== 0) begin fails++; $display("FAIL rst_no_write: mem=%h beat=%0d want 0 0", mem[8'hF0], dut.beat_cnt); end
        acc_idle();
        rst = 1;
        step();
        asserts++; if (acc_busy !== 0 || acc_gnt !== 0) begin fails++; $display("FAIL rst_release: busy=%b gnt=%b want 0 0", acc_busy, acc_gnt); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        test_reset();
        test_idle_priority();
        test_burst_read();
        test_forced_release();
        test_cpu_steal();
        test_bubble();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
